sha256_xmss_multiblock: RTL

SHA256_XMSS_MULTIBLOCK -- requirements
Module: sha256_xmss_multiblock

---
 rtl/sha256_xmss_multiblock.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_xmss_multiblock.sv
`default_nettype none
// ============================================================================
// sha256_xmss_multiblock : multi-block SHA-256 sequencer with stored midstates
// Revision 1.0
// ============================================================================
module sha256_xmss_multiblock #(
    parameter int MAX_BLOCKS = 4,
    parameter int SLOTS      = 2,
    parameter int WCNT_W     = $clog2(2*MAX_BLOCKS+1),
    parameter int SEL_W      = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WCNT_W-1:0] msg_words,
    input  logic              store_intermediate,
    input  logic              continue_intermediate,
    input  logic [SEL_W-1:0]  slot_sel,
    output logic              blk_req,
    input  logic              blk_valid,
    input  logic [511:0]      blk_data,
    output logic [255:0]      data_out,
    output logic              data_out_valid,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic [SLOTS-1:0]  slot_valid,
    output logic              sha256_start,
    output logic              sha256_init_message,
    output logic              sha256_init_iv,
    output logic [511:0]      sha256_data_in,
    input  logic [255:0]      sha256_data_out,
    input  logic              sha256_data_out_valid,
    input  logic              sha256_done,
    input  logic              sha256_busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_IV  = 3'd1,
        WAIT_BLK = 3'd2,
        COMPRESS = 3'd3,
        PAD      = 3'd4,
        FINISH   = 3'd5
    } state_t;

    localparam logic [WCNT_W:0] MAX_WORDS = (WCNT_W+1)'(2*MAX_BLOCKS);

    state_t            state;
    logic [WCNT_W-1:0] msg_q;
    logic [WCNT_W-1:0] remaining;
    logic              store_q;
    logic              cont_q;
    logic              first_blk;
    logic [SEL_W-1:0]  sel_q;
    logic [255:0]      slot_mem [SLOTS];

    logic              start_bad;
    logic [WCNT_W-1:0] blocks_needed;
    logic [63:0]       msg_len;
    logic              unused_core;

    // Completion is taken from sha256_done alone; the core's valid/busy are informational.
    assign unused_core = sha256_data_out_valid ^ sha256_busy;

    assign start_bad = (msg_words == '0)
                     || ({1'b0, msg_words} > MAX_WORDS)
                     || (store_intermediate && continue_intermediate)
                     || (store_intermediate && (msg_words < WCNT_W'(2)))
                     || (continue_intermediate && !slot_valid[slot_sel]);

    assign blocks_needed = (msg_words >> 1) + WCNT_W'(msg_words[0]);

    // A resumed hash already covers the 512-bit block folded into the midstate.
    assign msg_len = ({{(64-WCNT_W){1'b0}}, msg_q} << 8) + (cont_q ? 64'd512 : 64'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            msg_q               <= '0;
            remaining           <= '0;
            store_q             <= 1'b0;
            cont_q              <= 1'b0;
            first_blk           <= 1'b0;
            sel_q               <= '0;
            blk_req             <= 1'b0;
            data_out            <= '0;
            data_out_valid      <= 1'b0;
            done                <= 1'b0;
            busy                <= 1'b0;
            err                 <= 1'b0;
            slot_valid          <= '0;
            sha256_start        <= 1'b0;
            sha256_init_message <= 1'b0;
            sha256_init_iv      <= 1'b0;
            sha256_data_in      <= '0;
            for (int i = 0; i < SLOTS; i++) slot_mem[i] <= '0;
        end else begin
            done         <= 1'b0;
            err          <= 1'b0;
            sha256_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_bad) begin
                            err <= 1'b1;
                        end else begin
                            busy           <= 1'b1;
                            data_out_valid <= 1'b0;
                            msg_q          <= msg_words;
                            store_q        <= store_intermediate;
                            cont_q         <= continue_intermediate;
                            sel_q          <= slot_sel;
                            remaining      <= blocks_needed;
                            first_blk      <= 1'b1;
                            if (continue_intermediate) begin
                                state               <= LOAD_IV;
                                sha256_start        <= 1'b1;
                                sha256_init_iv      <= 1'b1;
                                sha256_init_message <= 1'b0;
                                sha256_data_in      <= {slot_mem[slot_sel], 256'd0};
                            end else begin
                                state   <= WAIT_BLK;
                                blk_req <= 1'b1;
                            end
                        end
                    end
                end
                LOAD_IV: begin
                    sha256_init_iv <= 1'b0;
                    blk_req        <= 1'b1;
                    state          <= WAIT_BLK;
                end
                WAIT_BLK: begin
                    if (blk_req && blk_valid) begin
                        blk_req             <= 1'b0;
                        remaining           <= remaining - WCNT_W'(1);
                        sha256_start        <= 1'b1;
                        sha256_init_message <= first_blk && !cont_q;
                        if ((remaining == WCNT_W'(1)) && msg_q[0])
                            sha256_data_in <= {blk_data[511:256], 32'h80000000, 160'd0, msg_len};
                        else
                            sha256_data_in <= blk_data;
                        state <= COMPRESS;
                    end
                end
                COMPRESS: begin
                    if (sha256_done) begin
                        sha256_init_message <= 1'b0;
                        first_blk           <= 1'b0;
                        if (first_blk && store_q) begin
                            slot_mem[sel_q]   <= sha256_data_out;
                            slot_valid[sel_q] <= 1'b1;
                        end
                        if (remaining != '0) begin
                            blk_req <= 1'b1;
                            state   <= WAIT_BLK;
                        end else if (!msg_q[0]) begin
                            sha256_start   <= 1'b1;
                            sha256_data_in <= {32'h80000000, 416'd0, msg_len};
                            state          <= PAD;
                        end else begin
                            done           <= 1'b1;
                            data_out       <= sha256_data_out;
                            data_out_valid <= 1'b1;
                            state          <= FINISH;
                        end
                    end
                end
                PAD: begin
                    if (sha256_done) begin
                        done           <= 1'b1;
                        data_out       <= sha256_data_out;
                        data_out_valid <= 1'b1;
                        state          <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
